// File: rtl/template_list_dispatch_if.sv
// Unit-side bus of template_list_dispatch: shared byte stream to the
// generator units plus their ready flags and end-of-list strobes.
interface template_list_dispatch_if #(
    parameter int NUM_UNITS = 4,
    parameter int UNIT_W    = 2,
    parameter int LEN_W     = 4,
    parameter int RI_W      = 8
);
    logic [NUM_UNITS-1:0] unit_ready;
    logic                 out_full;
    logic [UNIT_W-1:0]    out_unit;
    logic                 out_hdr;
    logic                 out_wr_en;
    logic [7:0]           out_data;
    logic                 out_last;
    logic [15:0]          out_word_id;
    logic [RI_W-1:0]      out_range_info;
    logic [LEN_W-1:0]     out_word_len;
    logic [NUM_UNITS-1:0] out_list_end;

    modport master (
        input  unit_ready, out_full,
        output out_unit, out_hdr, out_wr_en, out_data, out_last,
        output out_word_id, out_range_info, out_word_len,
        output out_list_end
    );

    modport slave (
        output unit_ready, out_full,
        input  out_unit, out_hdr, out_wr_en, out_data, out_last,
        input  out_word_id, out_range_info, out_word_len,
        input  out_list_end
    );
endinterface

// File: rtl/template_list_dispatch.sv
// Word-list read-side dispatcher: round-robin grant, header + byte stream.
// Optional bus stall support via TEMPLATE_DISPATCH_BACKPRESSURE_EN.
module template_list_dispatch #(
    parameter int WORD_MAX_LEN = 8,
    parameter int RANGES_MAX   = 2,
    parameter int NUM_UNITS    = 4,
    localparam int ADDR_W =
        (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1,
    localparam int LEN_W  = $clog2(WORD_MAX_LEN + 1),
    localparam int RANGE_INFO_MSB = ADDR_W,
    localparam int RI_W   = RANGES_MAX * (RANGE_INFO_MSB + 1),
    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              src_empty,
    input  logic [7:0]        src_dout,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [LEN_W-1:0]  src_word_len,
    input  logic [15:0]       src_word_id,
    input  logic [RI_W-1:0]   src_range_info,
    input  logic              src_list_end,
    output logic              src_set_empty,
    template_list_dispatch_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, GRANT, HDR, DATA, RELEASE, END_WAIT, END_BCAST
    } state_e;

    state_e            state_q, state_d;
    logic [UNIT_W-1:0] last_q, last_d;
    logic [UNIT_W-1:0] unit_q, unit_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       id_q, id_d;
    logic [RI_W-1:0]   ri_q, ri_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W:0]    nxt;
    logic              hit;
    logic [UNIT_W-1:0] pick;
    logic              stall;
    logic              last_byte;
    logic [7:0]        byte_cur;

`ifdef TEMPLATE_DISPATCH_BACKPRESSURE_EN
    logic [7:0] hold_q;
    logic       held_q;

    assign stall = bus.out_full
                 & ((state_q == HDR) | (state_q == DATA));
    assign byte_cur = held_q ? hold_q : src_dout;

    // Address already ran one ahead; park the pending byte here.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_q <= '0;
            held_q <= 1'b0;
        end else if (stall && state_q == DATA && !held_q) begin
            hold_q <= src_dout;
            held_q <= 1'b1;
        end else if (!stall) begin
            held_q <= 1'b0;
        end
    end
`else
    assign stall    = 1'b0 & bus.out_full;
    assign byte_cur = src_dout;
`endif

    // Lowest ready index above last_q wins, else lowest at/below it.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        for (int j = NUM_UNITS - 1; j >= 0; j--) begin
            if (bus.unit_ready[j] && UNIT_W'(j) <= last_q) begin
                hit  = 1'b1;
                pick = UNIT_W'(j);
            end
        end
        for (int j = NUM_UNITS - 1; j >= 0; j--) begin
            if (bus.unit_ready[j] && UNIT_W'(j) > last_q) begin
                hit  = 1'b1;
                pick = UNIT_W'(j);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        last_d           = last_q;
        unit_d           = unit_q;
        len_d            = len_q;
        cnt_d            = cnt_q;
        id_d             = id_q;
        ri_d             = ri_q;
        addr_d           = addr_q;
        last_byte        = 1'b0;
        nxt              = {1'b0, cnt_q} + (LEN_W + 1)'(2);
        src_set_empty    = 1'b0;
        bus.out_hdr      = 1'b0;
        bus.out_wr_en    = 1'b0;
        bus.out_last     = 1'b0;
        bus.out_data     = '0;
        bus.out_list_end = '0;
        unique case (state_q)
            IDLE: begin
                if (!src_empty)
                    state_d = src_list_end ? END_WAIT : GRANT;
            end
            GRANT: begin
                if (hit) begin
                    unit_d  = pick;
                    last_d  = pick;
                    len_d   = src_word_len;
                    id_d    = src_word_id;
                    ri_d    = src_range_info;
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (!stall) begin
                    bus.out_hdr  = 1'b1;
                    bus.out_last = (len_q == '0);
                    addr_d  = (len_q > LEN_W'(1)) ? ADDR_W'(1) : '0;
                    state_d = (len_q == '0) ? RELEASE : DATA;
                end
            end
            DATA: begin
                bus.out_data = byte_cur;
                last_byte    = (cnt_q + LEN_W'(1) == len_q);
                if (!stall) begin
                    bus.out_wr_en = 1'b1;
                    bus.out_last  = last_byte;
                    cnt_d         = cnt_q + LEN_W'(1);
                    if (nxt < {1'b0, len_q})
                        addr_d = nxt[ADDR_W-1:0];
                    if (last_byte)
                        state_d = RELEASE;
                end
            end
            RELEASE: begin
                src_set_empty = 1'b1;
                state_d       = IDLE;
            end
            END_WAIT: begin
                if (&bus.unit_ready)
                    state_d = END_BCAST;
            end
            END_BCAST: begin
                bus.out_list_end = '1;
                src_set_empty    = 1'b1;
                last_d           = UNIT_W'(NUM_UNITS - 1);
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            last_q  <= UNIT_W'(NUM_UNITS - 1);
            unit_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            ri_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            unit_q  <= unit_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ri_q    <= ri_d;
            addr_q  <= addr_d;
        end
    end

    assign src_rd_addr        = addr_q;
    assign bus.out_unit       = unit_q;
    assign bus.out_word_id    = id_q;
    assign bus.out_range_info = ri_q;
    assign bus.out_word_len   = len_q;
endmodule
